clock_time_counter: RTL and testbench

Time-keeping core of the clock design. It counts minutes and seconds in BCD from a one-second prescaler and lets the user set the time with two debounced push-buttons. Its 16-bit output feeds the four-digit seven-segment display driver directly. Any nibble driven as 4'hF is shown as a blank digit by that driver, and this block uses that to blink the field being edited.

---
 rtl/clock_time_counter.sv | 159 +++++++++++++++
 tb/tb_clock_time_counter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_counter.sv
`default_nettype none
// clock_time_counter: BCD mm:ss time-keeper with debounced mode/increment buttons
// and a blinking edit field (4'hF nibbles are blanked by the display driver).
module clock_time_counter #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int DB_CYCLES = 2_000_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [15:0] data,
  output logic [1:0]  mode,
  output logic        sec_tick
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] SET_MIN = 2'd1;
  localparam logic [1:0] SET_SEC = 2'd2;

  logic [1:0]    raw, sync1, sync2, level, level_d, press;
  logic [DW-1:0] db_cnt [2];
  logic          mode_p, inc_p, edit_inc;
  logic [1:0]    state, next_state;
  logic [TW-1:0] pcnt;
  logic          tick;
  logic [7:0]    mins, secs, mins_nxt, secs_nxt;
  logic [8:0]    min_inc, sec_inc;
  logic [BW-1:0] bcnt;
  logic          phase;

  // Returns {carry, tens, units}; the pair wraps 59 -> 00 with carry set.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] != 4'd9)
      return {1'b0, v[7:4], v[3:0] + 4'd1};
    else if (v[7:4] != 4'd5)
      return {1'b0, v[7:4] + 4'd1, 4'd0};
    else
      return 9'h100;
  endfunction

  assign raw = {btn_inc, btn_mode};

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        sync1[i]   <= 1'b0;
        sync2[i]   <= 1'b0;
        level[i]   <= 1'b0;
        level_d[i] <= 1'b0;
        db_cnt[i]  <= '0;
      end else begin
        sync1[i]   <= raw[i];
        sync2[i]   <= sync1[i];
        level_d[i] <= level[i];
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press    = level & ~level_d;
  assign mode_p   = press[0];
  assign inc_p    = press[1];
  // A mode press wins over a coincident increment.
  assign edit_inc = inc_p & ~mode_p;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (mode_p) begin
      case (state)
        RUN:     next_state = SET_MIN;
        SET_MIN: next_state = SET_SEC;
        default: next_state = RUN;
      endcase
    end
  end

  always_comb begin
    mode = state;
  end

  assign tick = (state == RUN) && (pcnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst || state != RUN || tick) pcnt <= '0;
    else                             pcnt <= pcnt + 1'b1;
  end

  always_comb begin
    min_inc  = bcd_inc(mins);
    sec_inc  = bcd_inc(secs);
    mins_nxt = mins;
    secs_nxt = secs;
    if (tick) begin
      secs_nxt = sec_inc[7:0];
      if (sec_inc[8]) mins_nxt = min_inc[7:0];
    end else if (edit_inc && state == SET_MIN) begin
      mins_nxt = min_inc[7:0];
    end else if (edit_inc && state == SET_SEC) begin
      secs_nxt = sec_inc[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mins     <= 8'h00;
      secs     <= 8'h00;
      sec_tick <= 1'b0;
    end else begin
      mins     <= mins_nxt;
      secs     <= secs_nxt;
      sec_tick <= tick;
    end
  end

  // Blink restarts visible on entering a set state and after every increment.
  always_ff @(posedge clk) begin
    if (rst || next_state == RUN || mode_p || inc_p) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == BLINK_LAST) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= 16'h0000;
    end else begin
      data[15:8] <= (phase && state == SET_MIN) ? 8'hFF : mins;
      data[7:0]  <= (phase && state == SET_SEC) ? 8'hFF : secs;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_time_counter.sv
`default_nettype none
// tb_clock_time_counter: directed scenarios for clock_time_counter with
// TICK_DIV=10, DB_CYCLES=4, BLINK_DIV=3.
module tb_clock_time_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_mode = 1'b0;
  logic        btn_inc = 1'b0;
  logic [15:0] data;
  logic [1:0]  mode;
  logic        sec_tick;

  int n_cmp  = 0;
  int n_fail = 0;
  int ticks_seen = 0;

  clock_time_counter #(
    .TICK_DIV (10),
    .DB_CYCLES(4),
    .BLINK_DIV(3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_mode(btn_mode),
    .btn_inc (btn_inc),
    .data    (data),
    .mode    (mode),
    .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sec_tick) ticks_seen++;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Raise the raw lines; returns on the sample where mode/time have taken the press.
  task automatic raise(input logic m, input logic i);
    btn_mode = m;
    btn_inc = i;
    repeat (7) @(negedge clk);
  endtask

  task automatic release_btns();
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    repeat (9) @(negedge clk);
  endtask

  task automatic press(input logic m, input logic i);
    raise(m, i);
    release_btns();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (data !== 16'h0000) begin n_fail++; $display("FAIL reset_data got %h want 0000", data); end
    n_cmp++;
    if (mode !== 2'd0) begin n_fail++; $display("FAIL reset_mode got %0d want 0", mode); end
    n_cmp++;
    if (sec_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b want 0", sec_tick); end
  endtask

  task automatic test_run();
    int cnt = 0;
    for (int i = 1; i <= 6000; i++) begin
      @(negedge clk);
      if (sec_tick === 1'b1) cnt++;
      if (i == 9) begin
        n_cmp++;
        if (sec_tick !== 1'b0) begin n_fail++; $display("FAIL early_tick got %b want 0", sec_tick); end
      end
      if (i == 10) begin
        n_cmp++;
        if (sec_tick !== 1'b1) begin n_fail++; $display("FAIL first_tick got %b want 1", sec_tick); end
        n_cmp++;
        if (data !== 16'h0000) begin n_fail++; $display("FAIL pre_tick_data got %h want 0000", data); end
      end
      if (i == 11) begin
        n_cmp++;
        if (data !== 16'h0001) begin n_fail++; $display("FAIL first_sec_data got %h want 0001", data); end
      end
    end
    @(negedge clk);
    n_cmp++;
    if (cnt !== 600) begin n_fail++; $display("FAIL tick_count got %0d want 600", cnt); end
    n_cmp++;
    if (data !== 16'h1000) begin n_fail++; $display("FAIL run_600_data got %h want 1000", data); end
  endtask

  task automatic test_debounce();
    bit bad = 0;
    int changes = 0;
    logic [1:0] prev;
    do_reset();
    for (int g = 0; g < 4; g++) begin
      btn_mode = 1'b1;
      repeat (3) begin @(negedge clk); if (mode !== 2'd0) bad = 1; end
      btn_mode = 1'b0;
      repeat (3) begin @(negedge clk); if (mode !== 2'd0) bad = 1; end
    end
    n_cmp++;
    if (bad) begin n_fail++; $display("FAIL glitch_mode got %0d want 0", mode); end
    prev = mode;
    btn_mode = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mode !== prev) changes++;
      prev = mode;
      if (k == 6) begin
        n_cmp++;
        if (mode !== 2'd0) begin n_fail++; $display("FAIL db_early got %0d want 0", mode); end
      end
      if (k == 7) begin
        n_cmp++;
        if (mode !== 2'd1) begin n_fail++; $display("FAIL db_at7 got %0d want 1", mode); end
      end
    end
    btn_mode = 1'b0;
    repeat (10) begin @(negedge clk); if (mode !== prev) changes++; prev = mode; end
    n_cmp++;
    if (changes !== 1) begin n_fail++; $display("FAIL db_once got %0d changes want 1", changes); end
  endtask

  task automatic test_set_minutes();
    int t0;
    do_reset();
    press(1'b1, 1'b0);
    n_cmp++;
    if (mode !== 2'd1) begin n_fail++; $display("FAIL enter_set_min got %0d want 1", mode); end
    t0 = ticks_seen;
    repeat (60) press(1'b0, 1'b1);
    raise(1'b0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (data !== 16'h0100) begin n_fail++; $display("FAIL min61_data got %h want 0100", data); end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (data !== 16'h0100) begin n_fail++; $display("FAIL blink_visible got %h want 0100", data); end
    @(negedge clk);
    n_cmp++;
    if (data !== 16'hFF00) begin n_fail++; $display("FAIL blink_blank got %h want ff00", data); end
    release_btns();
    n_cmp++;
    if (ticks_seen !== t0) begin n_fail++; $display("FAIL set_no_tick got %0d want %0d", ticks_seen, t0); end
  endtask

  task automatic test_rollover();
    int n;
    do_reset();
    press(1'b1, 1'b0);
    repeat (59) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    n_cmp++;
    if (mode !== 2'd2) begin n_fail++; $display("FAIL enter_set_sec got %0d want 2", mode); end
    repeat (58) press(1'b0, 1'b1);
    raise(1'b1, 1'b0);
    btn_mode = 1'b0;
    n_cmp++;
    if (mode !== 2'd0) begin n_fail++; $display("FAIL back_to_run got %0d want 0", mode); end
    @(negedge clk);
    n_cmp++;
    if (data !== 16'h5958) begin n_fail++; $display("FAIL preset_data got %h want 5958", data); end
    n = 1;
    while (sec_tick !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    n_cmp++;
    if (n !== 10) begin n_fail++; $display("FAIL restart_tick_delay got %0d want 10", n); end
    @(negedge clk);
    n_cmp++;
    if (data !== 16'h5959) begin n_fail++; $display("FAIL roll_5959 got %h want 5959", data); end
    n = 0;
    while (sec_tick !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    n_cmp++;
    if (sec_tick !== 1'b1) begin n_fail++; $display("FAIL second_tick got %b want 1", sec_tick); end
    @(negedge clk);
    n_cmp++;
    if (data !== 16'h0000) begin n_fail++; $display("FAIL roll_0000 got %h want 0000", data); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    repeat (30) press(1'b0, 1'b1);
    raise(1'b1, 1'b1);
    n_cmp++;
    if (mode !== 2'd0) begin n_fail++; $display("FAIL simul_mode got %0d want 0", mode); end
    @(negedge clk);
    n_cmp++;
    if (data[7:0] !== 8'h30) begin n_fail++; $display("FAIL simul_secs got %h want 30", data[7:0]); end
    n_cmp++;
    if (data[15:8] !== 8'h00) begin n_fail++; $display("FAIL simul_mins got %h want 00", data[15:8]); end
    release_btns();
  endtask

  task automatic test_reset_mid_set();
    do_reset();
    press(1'b1, 1'b0);
    repeat (12) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    repeat (34) press(1'b0, 1'b1);
    n_cmp++;
    if (mode !== 2'd2 || data[15:8] !== 8'h12) begin
      n_fail++; $display("FAIL preset_1234 got mode %0d mins %h want 2 12", mode, data[15:8]);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (data !== 16'h0000) begin n_fail++; $display("FAIL midset_rst_data got %h want 0000", data); end
    n_cmp++;
    if (mode !== 2'd0) begin n_fail++; $display("FAIL midset_rst_mode got %0d want 0", mode); end
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i < 10) begin
        n_cmp++;
        if (sec_tick !== 1'b0) begin n_fail++; $display("FAIL post_rst_tick%0d got %b want 0", i, sec_tick); end
      end else begin
        n_cmp++;
        if (sec_tick !== 1'b1) begin n_fail++; $display("FAIL post_rst_first_tick got %b want 1", sec_tick); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_debounce();
    test_set_minutes();
    test_rollover();
    test_simultaneous();
    test_reset_mid_set();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
